// File: rtl/reg8_write_arbiter.sv
// Round-robin write scheduler sharing a bank of N_REG 8-bit registers among N_REQ requesters.
// Optional burst locking (LOCKED state, busy) is compiled in when ARB_LOCK_EN is defined.
module reg8_write_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned N_REG = 4,
    localparam int unsigned AW = $clog2(N_REG),
    localparam int unsigned OW = $clog2(N_REQ)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*8-1:0]  req_data,
    input  logic [N_REQ-1:0]    req_lock,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REG-1:0]    reg_en,
    output logic [7:0]          reg_din,
    output logic                addr_err,
    output logic                busy,
    output logic [OW-1:0]       owner
);

    localparam int unsigned DW   = 8;
    localparam int unsigned NADR = 1 << AW;

    // Bit a set when address a hits a real register in the bank.
    localparam logic [NADR-1:0]  ADDR_OK = {NADR{1'b1}} >> (NADR - N_REG);
    localparam logic [N_REG-1:0] EN_ONE  = N_REG'(1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     ptr_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [N_REG-1:0]  reg_en_nxt;
    logic [DW-1:0]     reg_din_nxt;
    logic              addr_err_nxt;
    logic              busy_nxt;
    logic [OW-1:0]     owner_nxt;

    wr_t               wr [N_REQ];
    logic [N_REQ-1:0]  elig_c;
    logic              win_valid_c;
    logic [OW-1:0]     win_idx_c;
    logic [OW-1:0]     cand_c;
    logic              grant_c;
    logic [OW-1:0]     sel_c;
    wr_t               sel_wr_c;

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Split the flat request buses into per-requester write payloads.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign wr[i] = {req_addr[i*AW +: AW], req_data[i*DW +: DW]};
    end

    // A requester granted this cycle sits out the next edge.
    assign elig_c = req & ~gnt;

    // Circular search for the first eligible requester starting at ptr.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_c = OW'((32'(ptr) + k) % N_REQ);
            if (!win_valid_c && elig_c[cand_c]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_nxt      = '0;
        reg_en_nxt   = '0;
        reg_din_nxt  = reg_din;
        addr_err_nxt = 1'b0;
        owner_nxt    = owner;
        busy_nxt     = 1'b0;
        grant_c      = 1'b0;
        sel_c        = win_idx_c;
        sel_wr_c     = '0;

        unique case (state)
            IDLE: begin
                grant_c = win_valid_c;
`ifdef ARB_LOCK_EN
                if (win_valid_c && req_lock[win_idx_c]) begin
                    state_nxt = LOCKED;
                end
`endif
            end
            LOCKED: begin
`ifdef ARB_LOCK_EN
                // Owner keeps the bus regardless of its current grant.
                sel_c   = owner;
                grant_c = req[owner];
                if (!(req[owner] && req_lock[owner])) begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase

        sel_wr_c = wr[sel_c];
        if (grant_c) begin
            gnt_nxt[sel_c] = 1'b1;
            owner_nxt      = sel_c;
            reg_din_nxt    = sel_wr_c.data;
            if (ADDR_OK[sel_wr_c.addr]) begin
                reg_en_nxt = EN_ONE << sel_wr_c.addr;
            end else begin
                addr_err_nxt = 1'b1;
            end
            ptr_nxt = (32'(sel_c) == N_REQ - 1) ? '0 : sel_c + OW'(1);
        end

`ifdef ARB_LOCK_EN
        busy_nxt = (state_nxt == LOCKED);
`endif
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            reg_en   <= '0;
            reg_din  <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
            owner    <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            reg_en   <= reg_en_nxt;
            reg_din  <= reg_din_nxt;
            addr_err <= addr_err_nxt;
            busy     <= busy_nxt;
            owner    <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Testbench for reg8_write_arbiter: directed vectors checked against a cycle-level model,
// using a 4-register bank and a 3-register bank (for out-of-range addresses) driven in parallel.
module tb_reg8_write_arbiter;

`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [7:0]  req_addr;
    logic [31:0] req_data;

    logic [3:0]  gnt_a, gnt_b;
    logic [3:0]  en_a;
    logic [2:0]  en_b;
    logic [7:0]  din_a, din_b;
    logic        err_a, err_b;
    logic        busy_a, busy_b;
    logic [1:0]  own_a, own_b;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg8_write_arbiter #(.N_REQ(4), .N_REG(4)) u_dut (
        .Clk(clk), .Reset(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_lock(req_lock), .gnt(gnt_a), .reg_en(en_a), .reg_din(din_a),
        .addr_err(err_a), .busy(busy_a), .owner(own_a)
    );

    reg8_write_arbiter #(.N_REQ(4), .N_REG(3)) u_dut3 (
        .Clk(clk), .Reset(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_lock(req_lock), .gnt(gnt_b), .reg_en(en_b), .reg_din(din_b),
        .addr_err(err_b), .busy(busy_b), .owner(own_b)
    );

    // Model of what the outputs hold after each edge.
    int         m_ptr    = 0;
    int         m_owner  = 0;
    int         m_addr   = 0;
    bit         m_locked = 1'b0;
    bit         m_wr     = 1'b0;
    logic [3:0] m_gnt    = 4'h0;
    logic [7:0] m_din    = 8'h00;

    always @(posedge clk) begin
        int win;
        win = -1;
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_gnt = 4'h0; m_din = 8'h00; m_wr = 1'b0;
        end else begin
            if (m_locked) begin
                if (req[m_owner]) win = m_owner;
                m_locked = (win >= 0) && req_lock[m_owner];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_ptr + k) % 4;
                    if (win < 0 && req[c] && !m_gnt[c]) win = c;
                end
                m_locked = LOCK_EN && (win >= 0) && req_lock[win];
            end
            m_gnt = 4'h0;
            m_wr  = (win >= 0);
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                m_owner    = win;
                m_din      = req_data[win*8 +: 8];
                m_addr     = int'(req_addr[win*2 +: 2]);
                m_ptr      = (win + 1) % 4;
            end
        end
    end

    function automatic logic [31:0] exp_en(input int nreg);
        if (!m_wr || m_addr >= nreg) return 32'h0;
        return 32'h1 << m_addr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",        32'(gnt_a),  32'(m_gnt));
            check("gnt_b",      32'(gnt_b),  32'(m_gnt));
            check("reg_en",     32'(en_a),   exp_en(4));
            check("reg_en_b",   32'(en_b),   exp_en(3));
            check("reg_din",    32'(din_a),  32'(m_din));
            check("reg_din_b",  32'(din_b),  32'(m_din));
            check("addr_err",   32'(err_a),  32'(m_wr && m_addr >= 4));
            check("addr_err_b", 32'(err_b),  32'(m_wr && m_addr >= 3));
            check("busy",       32'(busy_a), 32'(m_locked));
            check("busy_b",     32'(busy_b), 32'(m_locked));
            check("owner",      32'(own_a),  32'(m_owner));
            check("owner_b",    32'(own_b),  32'(m_owner));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put(input int i, input logic r, input logic [1:0] a, input logic [7:0] d,
                       input logic l);
        req[i]           = r;
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
        req_lock[i]      = l;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_lock = '0; req_addr = '0; req_data = '0;
        repeat (2) step();
        chk_en = 1'b1;
        check("rst gnt",     32'(gnt_a), 32'h0);
        check("rst reg_en",  32'(en_a),  32'h0);
        check("rst reg_din", 32'(din_a), 32'h0);
        check("rst busy",    32'(busy_a), 32'h0);
        check("rst owner",   32'(own_a), 32'h0);
        rst = 1'b0;

        // Idle: no activity.
        repeat (5) begin
            step();
            check("idle gnt",    32'(gnt_a), 32'h0);
            check("idle reg_en", 32'(en_a),  32'h0);
        end

        // Single write.
        put(0, 1'b1, 2'd2, 8'hA5, 1'b0);
        step();
        check("single gnt",     32'(gnt_a), 32'h1);
        check("single reg_en",  32'(en_a),  32'h4);
        check("single reg_din", 32'(din_a), 32'hA5);
        put(0, 1'b0, 2'd2, 8'hA5, 1'b0);
        step();
        check("single after gnt",    32'(gnt_a), 32'h0);
        check("single after reg_en", 32'(en_a),  32'h0);
        check("single hold reg_din", 32'(din_a), 32'hA5);

        // Fairness with all four requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) put(i, 1'b1, 2'(i), 8'(16 + i), 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr gnt", 32'(gnt_a), 32'h1 << (k % 4));
        end
        req = '0;
        step();

        // Out-of-range address on the 3-register bank.
        put(1, 1'b1, 2'd3, 8'h5A, 1'b0);
        step();
        check("badaddr gnt_b",      32'(gnt_b), 32'h2);
        check("badaddr reg_en_b",   32'(en_b),  32'h0);
        check("badaddr addr_err_b", 32'(err_b), 32'h1);
        check("badaddr reg_en",     32'(en_a),  32'h8);
        check("badaddr addr_err",   32'(err_a), 32'h0);
        put(1, 1'b0, 2'd3, 8'h5A, 1'b0);
        step();
        check("badaddr pulse",      32'(err_b), 32'h0);

        // Single requester held: no back-to-back grants.
        put(2, 1'b1, 2'd1, 8'h33, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("b2b gnt", 32'(gnt_a), (k % 2 == 0) ? 32'h4 : 32'h0);
        end
        put(2, 1'b0, 2'd1, 8'h33, 1'b0);
        step();

        // Simultaneous requests resolved from the pointer (now 3).
        put(0, 1'b1, 2'd0, 8'h01, 1'b0);
        put(1, 1'b1, 2'd1, 8'h02, 1'b0);
        put(3, 1'b1, 2'd3, 8'h04, 1'b0);
        step();
        check("ptr order 1", 32'(gnt_a), 32'h8);
        step();
        check("ptr order 2", 32'(gnt_a), 32'h1);
        step();
        check("ptr order 3", 32'(gnt_a), 32'h2);
        req = '0;
        step();

        // Lock burst (or lock ignored when the feature is absent).
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef ARB_LOCK_EN
        put(2, 1'b1, 2'd1, 8'h21, 1'b1);
        step();
        check("lock w1 gnt",  32'(gnt_a), 32'h4);
        check("lock w1 busy", 32'(busy_a), 32'h1);
        put(2, 1'b1, 2'd1, 8'h22, 1'b1);
        put(0, 1'b1, 2'd0, 8'h01, 1'b0);
        step();
        check("lock w2 gnt",  32'(gnt_a), 32'h4);
        check("lock w2 din",  32'(din_a), 32'h22);
        put(2, 1'b1, 2'd1, 8'h23, 1'b1);
        step();
        check("lock w3 gnt",  32'(gnt_a), 32'h4);
        check("lock w3 busy", 32'(busy_a), 32'h1);
        put(2, 1'b1, 2'd1, 8'h24, 1'b0);
        step();
        check("lock w4 gnt",  32'(gnt_a), 32'h4);
        check("lock w4 busy", 32'(busy_a), 32'h0);
        check("lock w4 din",  32'(din_a), 32'h24);
        put(2, 1'b0, 2'd1, 8'h24, 1'b0);
        step();
        check("lock next gnt", 32'(gnt_a), 32'h1);
`else
        put(2, 1'b1, 2'd1, 8'h21, 1'b1);
        step();
        check("nolock w1 gnt",  32'(gnt_a), 32'h4);
        check("nolock w1 busy", 32'(busy_a), 32'h0);
        put(0, 1'b1, 2'd0, 8'h01, 1'b0);
        step();
        check("nolock w2 gnt",  32'(gnt_a), 32'h1);
        step();
        check("nolock w3 gnt",  32'(gnt_a), 32'h4);
        put(2, 1'b0, 2'd1, 8'h21, 1'b0);
`endif
        req = '0; req_lock = '0;
        step();

        // Reset in the second locked cycle.
        put(1, 1'b1, 2'd0, 8'h44, 1'b1);
        step();
        step();
        check("midlock busy", 32'(busy_a), 32'(LOCK_EN));
        rst = 1'b1;
        step();
        check("midrst busy",  32'(busy_a), 32'h0);
        check("midrst gnt",   32'(gnt_a),  32'h0);
        check("midrst din",   32'(din_a),  32'h0);
        check("midrst owner", 32'(own_a),  32'h0);
        rst = 1'b0;
        put(1, 1'b0, 2'd0, 8'h44, 1'b0);
        put(0, 1'b1, 2'd3, 8'h55, 1'b0);
        put(3, 1'b1, 2'd2, 8'h66, 1'b0);
        step();
        check("midrst ptr", 32'(gnt_a), 32'h1);
        req = '0;
        repeat (2) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg8_write_arbiter.md
# reg8_write_arbiter

Round-robin write scheduler that shares a bank of N_REG 8-bit enable-gated registers among N_REQ requesters. Each cycle it selects at most one pending write, drives the shared 8-bit data bus and the one-hot write enable of the addressed register, and returns a one-cycle grant to the winner. It sits between the game-logic requesters (input decoder, maze state updater, hangman scorer) and the register bank whose storage elements load on `En` at the clock edge.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `N_REG`, 4: number of 8-bit registers in the bank, 2..16.
- `AW`, `$clog2(N_REG)`: register address width; derived, not overridden.
- `Clk` in 1: single system clock, rising edge.
- `Reset` in 1: synchronous, active-high; sampled on `Clk` rising edge.
- `req` in N_REQ: write request per requester; held until granted.
- `req_addr` in N_REQ*AW: target register per requester; requester i occupies bits [i*AW +: AW].
- `req_data` in N_REQ*8: write data per requester; requester i occupies bits [i*8 +: 8].
- `req_lock` in N_REQ: burst-lock request per requester; ignored unless ARB_LOCK_EN.
- `gnt` out N_REQ: one-hot grant, registered, one cycle per accepted write.
- `reg_en` out N_REG: one-hot write enable to the bank, registered.
- `reg_din` out 8: shared data bus to the bank, registered.
- `addr_err` out 1: one-cycle pulse when the accepted write addresses a register ≥ N_REG.
- `busy` out 1: high while the FSM is in LOCKED.
- `owner` out $clog2(N_REQ): index of the last granted requester.

## Operation
- Reset values: `gnt`=0, `reg_en`=0, `reg_din`=8'h00, `addr_err`=0, `busy`=0, `owner`=0. Round-robin pointer `ptr`=0. FSM state IDLE.
- Eligible set in IDLE: `req & ~gnt`. A requester granted in the current cycle cannot win the next edge. Without a lock, the maximum rate is one write per requester every 2 cycles.
- Winner: the first eligible index searched circularly from `ptr` (ptr, ptr+1, …, wrapping at N_REQ).
- On a win by requester i at an edge:
  - `gnt[i]`=1 and `owner`=i.
  - `reg_din` = data of requester i.
  - `reg_en[addr_i]`=1 if addr_i < N_REG; otherwise `reg_en` stays 0 and `addr_err`=1.
  - `ptr` = (i+1) mod N_REQ.
- No eligible requester: all of `gnt`, `reg_en` and `addr_err` are 0 next cycle. `reg_din` holds its last value. `ptr` is unchanged.
- Requester protocol:
  - Drop `req`, or present the next write's addr/data, in the cycle `gnt` is seen.
  - Do not change addr/data while `req` is high and ungranted.
- FSM states: IDLE and LOCKED. LOCKED is reachable only with ARB_LOCK_EN.
  - IDLE → LOCKED: the winner has `req_lock` high at the winning edge.
  - LOCKED, owner `req`=1 and `req_lock`=1: grant the owner again at this edge, regardless of its current `gnt`; stay LOCKED.
  - LOCKED, owner `req`=1 and `req_lock`=0: grant the final write; go to IDLE.
  - LOCKED, owner `req`=0: no grant; go to IDLE.
  - `ptr` = owner+1 on every LOCKED grant. Other requesters wait.
- `busy` = (state == LOCKED), registered.

## Timing
- Latency: `req` sampled at edge t produces `gnt`, `reg_en` and `reg_din` valid during cycle t+1. The bank register loads at edge t+2.
- `reg_en` and `gnt` are high together for exactly one cycle per write.
- Simultaneous requests at one edge: exactly one grant, chosen by pointer order.
- Reset asserted during any state, including LOCKED: at the next edge all outputs and `ptr` take their reset values and the FSM enters IDLE. Any write pending in that cycle is discarded.
- Pointer wrap: a grant to N_REQ-1 sets `ptr`=0.

## Configuration
- `ARB_LOCK_EN` defined: `req_lock` is honoured and the LOCKED state, burst grants and `busy` behave as described above.
- `ARB_LOCK_EN` not defined:
  - `req_lock` port is present but ignored.
  - FSM never leaves IDLE and `busy` is tied to 0.
  - All grants follow the IDLE rules, including the no-back-to-back exclusion.

## Test plan
- Reset then idle: after `Reset` pulse, all outputs 0 and `ptr`=0. `req`=0 for 5 cycles → no `gnt` or `reg_en` activity.
- Single write: req0 with addr=2, data=8'hA5 at edge t → cycle t+1 `gnt`=4'b0001, `reg_en`=4'b0100, `reg_din`=8'hA5. Next cycle all 0.
- Fairness: all 4 requesters held high → grants in order 0,1,2,3,0,… with one grant per cycle and no index repeated consecutively.
- Bad address: N_REG=3, req1 with addr=3 → `gnt[1]`=1, `reg_en`=0, `addr_err`=1 for one cycle.
- Lock burst (ARB_LOCK_EN): req2 with lock high for 3 writes while req0 is pending → `gnt[2]` high 3 consecutive cycles and `busy`=1. Lock dropped on the 4th write → that write granted, then `gnt[0]` on the next edge.
- Reset mid-lock: `Reset` in the 2nd LOCKED cycle → next cycle `busy`=0, `gnt`=0, `ptr`=0, FSM in IDLE.
